// File: rtl/outbyte_arbiter.sv
// Shares one outbyte115200 transmitter among NREQ requesters with per-requester byte latches and round-robin grant.
// Optional OUTBYTE_ARB_LINE_LOCK_EN: hold the grant on one requester until its LF byte completes.
module outbyte_arbiter #(
  parameter int          NREQ = 4,
  parameter logic [7:0]  LF   = 8'h0A,
  localparam int         PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_start,
  input  logic [8*NREQ-1:0] req_byte,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   req_overrun,
  output logic              dn_start,
  output logic [7:0]        dn_byte,
  input  logic              dn_ready,
  output logic [PW-1:0]     grant_id,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Handshake: req_start[i] is a one-cycle call, accepted only while req_ready[i]=1;
  // dn_start is a one-cycle pulse issued only after dn_ready=1 was seen in IDLE.

  state_t          state, state_nx;
  logic [NREQ-1:0] pend;
  logic [7:0]      hold [NREQ];
  logic [PW-1:0]   rr_ptr;
  logic            wait_armed;
  logic            pick_found;
  logic [PW-1:0]   pick_id;
  logic            done;

`ifdef OUTBYTE_ARB_LINE_LOCK_EN
  logic            locked;
`endif

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  assign req_ready = ~pend;
  assign dn_start  = (state == S_ISSUE);
  assign state_dbg = state;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr;
    // Walk from farthest to nearest so the nearest pending requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pend[wrap_add(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_id    = wrap_add(rr_ptr, k);
      end
    end
`ifdef OUTBYTE_ARB_LINE_LOCK_EN
    if (locked) begin
      pick_found = pend[grant_id];
      pick_id    = grant_id;
    end
`endif
    state_nx = state;
    done     = 1'b0;
    case (state)
      S_IDLE:  if (pick_found && dn_ready) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // First WAIT cycle ignores dn_ready: it may still be the pre-start value.
        if (wait_armed && dn_ready) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pend        <= '0;
      req_overrun <= '0;
      dn_byte     <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      wait_armed  <= 1'b0;
`ifdef OUTBYTE_ARB_LINE_LOCK_EN
      locked      <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      wait_armed <= (state == S_WAIT);
      for (int i = 0; i < NREQ; i++) begin
        if (req_start[i]) begin
          if (!pend[i]) begin
            pend[i] <= 1'b1;
            hold[i] <= req_byte[8*i +: 8];
          end else begin
            req_overrun[i] <= 1'b1;
          end
        end
      end
      if (state == S_IDLE && state_nx == S_ISSUE) begin
        grant_id <= pick_id;
        dn_byte  <= hold[pick_id];
`ifdef OUTBYTE_ARB_LINE_LOCK_EN
        locked   <= 1'b1;
`endif
      end
      if (done) begin
        pend[grant_id] <= 1'b0;
`ifdef OUTBYTE_ARB_LINE_LOCK_EN
        if (dn_byte == LF) begin
          locked <= 1'b0;
          rr_ptr <= wrap_add(grant_id, 1);
        end
`else
        rr_ptr <= wrap_add(grant_id, 1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_outbyte_arbiter.sv
// Directed bench for outbyte_arbiter: scoreboard queue of {grant_id, dn_byte} checked by a dn_start monitor.
module tb_outbyte_arbiter;
  localparam int NREQ = 4;
  localparam int PW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_start;
  logic [8*NREQ-1:0] req_byte;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_overrun;
  logic              dn_start;
  logic [7:0]        dn_byte;
  logic              dn_ready;
  logic [PW-1:0]     grant_id;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  outbyte_arbiter #(.NREQ(NREQ), .LF(8'h0A)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_start(req_start), .req_byte(req_byte),
    .req_ready(req_ready), .req_overrun(req_overrun),
    .dn_start(dn_start), .dn_byte(dn_byte), .dn_ready(dn_ready),
    .grant_id(grant_id), .state_dbg(state_dbg)
  );

  // Downstream model: dn_ready stays high one cycle after start, then low for 4 cycles.
  logic dn_hold = 1'b0;
  logic dn_seen = 1'b0;
  int   dn_busy = 0;
  always @(posedge clk) begin
    if (dn_seen) dn_busy <= 4;
    else if (dn_busy > 0) dn_busy <= dn_busy - 1;
    dn_seen <= dn_start;
  end
  assign dn_ready = (dn_busy == 0) && !dn_hold;

  a_no_double_start: assert property (@(posedge clk) disable iff (!rst_n) dn_start |=> !dn_start)
    else $error("FAIL dn_start_double");

  // scoreboard monitor
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (dn_start) begin
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL dn_start_consecutive: got high two cycles, required single pulse");
      end
      checks++;
      if (dn_seen || dn_busy != 0) begin
        errors++;
        $display("FAIL dn_start_busy: start while downstream busy (busy=%0d)", dn_busy);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dn_unexpected: got id=%0d byte=%h, required no transfer", grant_id, dn_byte);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({grant_id, dn_byte} !== e) begin
          errors++;
          $display("FAIL dn_xfer: got id=%0d byte=%h, required id=%0d byte=%h",
                   grant_id, dn_byte, e[9:8], e[7:0]);
        end
      end
    end
    prev_start = dn_start;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] put(input int i, input logic [7:0] b);
    logic [31:0] v;
    v = '0;
    v[8*i +: 8] = b;
    return v;
  endfunction

  task automatic call(input logic [NREQ-1:0] mask, input logic [31:0] bytes);
    req_start = mask;
    req_byte  = bytes;
    @(negedge clk);
    req_start = '0;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!req_ready[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL wait_ready_timeout: req %0d ready=0, required 1", i);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(req_ready == 4'hF && state_dbg == 2'd0 && dn_ready && exp_q.size() == 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL drain_timeout: ready=%b pending_exp=%0d, required idle", req_ready, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    logic bad;
    rst_n = 1'b0;
    req_start = '0;
    req_byte = '0;
    tick(3);
    check("rst_ready", 32'(req_ready), 32'hF);
    check("rst_overrun", 32'(req_overrun), 32'h0);
    check("rst_dn_start", 32'(dn_start), 32'h0);
    check("rst_dn_byte", 32'(dn_byte), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // single call: start in cycle 2, ready low through completion cycle 8
    exp_q.push_back({2'd2, 8'h41});
    call(4'b0100, put(2, 8'h41));
    check("t1_ready_c1", 32'(req_ready[2]), 32'h0);
    tick(1);
    check("t1_start_c2", 32'(dn_start), 32'h1);
    check("t1_byte_c2", 32'(dn_byte), 32'h41);
    bad = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      tick(1);
      if (req_ready[2] !== 1'b0) bad = 1'b1;
    end
    check("t1_ready_low_c3_8", 32'(bad), 32'h0);
    tick(1);
    check("t1_ready_c9", 32'(req_ready[2]), 32'h1);
    drain();

`ifndef OUTBYTE_ARB_LINE_LOCK_EN
    // simultaneous calls, round-robin from 0, then from 2
    do_reset();
    exp_q.push_back({2'd0, 8'h30});
    exp_q.push_back({2'd1, 8'h31});
    exp_q.push_back({2'd2, 8'h32});
    exp_q.push_back({2'd3, 8'h33});
    call(4'hF, 32'h33323130);
    drain();
    check("t2_last_grant", 32'(grant_id), 32'h3);
    exp_q.push_back({2'd1, 8'h51});
    call(4'b0010, put(1, 8'h51));
    drain();
    check("t2_grant1", 32'(grant_id), 32'h1);
    exp_q.push_back({2'd2, 8'h32});
    exp_q.push_back({2'd3, 8'h33});
    exp_q.push_back({2'd0, 8'h30});
    exp_q.push_back({2'd1, 8'h31});
    call(4'hF, 32'h33323130);
    drain();
    check("t2_rot_last_grant", 32'(grant_id), 32'h1);
`endif

    // overrun: second call while not ready is dropped
    do_reset();
    check("t3_overrun_clear", 32'(req_overrun), 32'h0);
    exp_q.push_back({2'd1, 8'h61});
    call(4'b0010, put(1, 8'h61));
    call(4'b0010, put(1, 8'h62));
    check("t3_overrun_set", 32'(req_overrun), 32'h2);
    drain();
    check("t3_overrun_sticky", 32'(req_overrun), 32'h2);

    // downstream not ready at reset release
    dn_hold = 1'b1;
    do_reset();
    check("t4_overrun_rst", 32'(req_overrun), 32'h0);
    exp_q.push_back({2'd0, 8'h71});
    call(4'b0001, put(0, 8'h71));
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (dn_start || state_dbg != 2'd0) bad = 1'b1;
      tick(1);
    end
    check("t4_no_issue_held", 32'(bad), 32'h0);
    check("t4_ready0_low", 32'(req_ready[0]), 32'h0);
    dn_hold = 1'b0;
    drain();

    // reset during WAIT drops pending bytes
    exp_q.push_back({2'd3, 8'h72});
    call(4'b1000, put(3, 8'h72));
    begin
      int n;
      n = 0;
      while (state_dbg != 2'd2 && n < 20) begin
        tick(1);
        n++;
      end
      check("t4_reach_wait", 32'(state_dbg), 32'h2);
    end
    call(4'b0010, put(1, 8'h74));
    rst_n = 1'b0;
    tick(1);
    check("t4_rst_ready", 32'(req_ready), 32'hF);
    check("t4_rst_state", 32'(state_dbg), 32'h0);
    check("t4_rst_byte", 32'(dn_byte), 32'h0);
    rst_n = 1'b1;
    tick(15);
    check("t4_no_reissue", 32'(exp_q.size()), 32'h0);
    drain();

    // line lock interleave
    do_reset();
`ifdef OUTBYTE_ARB_LINE_LOCK_EN
    exp_q.push_back({2'd0, 8'h41});
    exp_q.push_back({2'd0, 8'h42});
    exp_q.push_back({2'd0, 8'h0A});
    exp_q.push_back({2'd1, 8'h78});
`else
    exp_q.push_back({2'd0, 8'h41});
    exp_q.push_back({2'd1, 8'h78});
    exp_q.push_back({2'd0, 8'h42});
    exp_q.push_back({2'd0, 8'h0A});
`endif
    call(4'b0001, put(0, 8'h41));
    tick(2);
    call(4'b0010, put(1, 8'h78));
    wait_ready(0);
    call(4'b0001, put(0, 8'h42));
    wait_ready(0);
    call(4'b0001, put(0, 8'h0A));
    drain();
`ifdef OUTBYTE_ARB_LINE_LOCK_EN
    check("t5_last_grant", 32'(grant_id), 32'h1);
`else
    check("t5_last_grant", 32'(grant_id), 32'h0);
`endif

    // final report
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
